// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register.
// Operation encodings and the drain-depth calculation live here.
package usr_pkg;

  typedef enum logic [2:0] {
    USR_HOLD = 3'b000,
    USR_SHL  = 3'b001,
    USR_SHR  = 3'b010,
    USR_ASR  = 3'b011,
    USR_LOAD = 3'b100,
    USR_ROL  = 3'b101,
    USR_ROR  = 3'b110,
    USR_CLR  = 3'b111
  } usr_op_e;

  // Number of STEP-bit shifts needed to push every loaded bit out of the register.
  function automatic int unsigned usr_depth(input int unsigned n, input int unsigned step);
    return (n + step - 1) / step;
  endfunction

endpackage

// File: rtl/usr_next_value.sv
// Combinational next-state datapath for the universal shift register.
// Build macro USR_ROTATE_EN enables ROL/ROR; without it those ops act as HOLD.
module usr_next_value
  import usr_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned STEP = 1
) (
  input  logic [N-1:0]    q,
  input  logic [2:0]      op,
  input  logic [N-1:0]    d,
  input  logic [STEP-1:0] sin_l,
  input  logic [STEP-1:0] sin_r,
  output logic [N-1:0]    q_nxt,
  output logic            is_shift
);

  usr_op_e w_op;

  assign w_op = usr_op_e'(op);

  always_comb begin
    q_nxt    = q;
    is_shift = 1'b0;
    unique case (w_op)
      USR_HOLD: q_nxt = q;
      USR_SHL: begin
        q_nxt    = {q[N-STEP-1:0], sin_l};
        is_shift = 1'b1;
      end
      USR_SHR: begin
        q_nxt    = {sin_r, q[N-1:STEP]};
        is_shift = 1'b1;
      end
      USR_ASR: begin
        q_nxt    = {{STEP{q[N-1]}}, q[N-1:STEP]};
        is_shift = 1'b1;
      end
      USR_LOAD: q_nxt = d;
`ifdef USR_ROTATE_EN
      USR_ROL: begin
        q_nxt    = {q[N-STEP-1:0], q[N-1 -: STEP]};
        is_shift = 1'b1;
      end
      USR_ROR: begin
        q_nxt    = {q[STEP-1:0], q[N-1:STEP]};
        is_shift = 1'b1;
      end
`else
      USR_ROL: q_nxt = q;
      USR_ROR: q_nxt = q;
`endif
      USR_CLR: q_nxt = '0;
      default: q_nxt = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with saturating shift counter and drained flag.
// Build macro USR_ROTATE_EN enables ROL/ROR; default build treats them as HOLD.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned STEP = 1,
  localparam int unsigned DEPTH = usr_depth(N, STEP),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [N-1:0]    d,
  input  logic [STEP-1:0] sin_l,
  input  logic [STEP-1:0] sin_r,
  output logic [N-1:0]    q,
  output logic [STEP-1:0] sout_l,
  output logic [STEP-1:0] sout_r,
  output logic [CW-1:0]   cnt,
  output logic            drained
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_drained;

  logic [N-1:0]  w_q_nxt;
  logic          w_is_shift;
  logic [CW-1:0] w_cnt_nxt;
  usr_op_e       w_op;

  assign w_op = usr_op_e'(op);

  usr_next_value #(
    .N    (N),
    .STEP (STEP)
  ) u_next (
    .q        (r_q),
    .op       (op),
    .d        (d),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .q_nxt    (w_q_nxt),
    .is_shift (w_is_shift)
  );

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_op == USR_LOAD || w_op == USR_CLR) begin
      w_cnt_nxt = '0;
    end else if (w_is_shift && r_cnt != DEPTH_C) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // drained is computed from the next count so it is a flop output, not a compare on q-side timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      r_cnt     <= '0;
      r_drained <= 1'b0;
    end else if (en) begin
      r_q       <= w_q_nxt;
      r_cnt     <= w_cnt_nxt;
      r_drained <= (w_cnt_nxt == DEPTH_C);
    end
  end

  assign q       = r_q;
  assign sout_l  = r_q[N-1 -: STEP];
  assign sout_r  = r_q[STEP-1:0];
  assign cnt     = r_cnt;
  assign drained = r_drained;

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised N-bit universal shift register: parallel load, logical and arithmetic shifts, optional rotates and synchronous clear, all by a configurable STEP bits per cycle. A shift counter reports how many shift steps have run since the last load, and a drained flag marks when the loaded word has been fully shifted out. It is the general-purpose successor to the fixed-function registers in the Shift Registers library. It is intended for serialisers, deserialisers and bit-manipulation datapaths.

## Interface
- N, default 8: register width in bits; N ≥ 2.
- STEP, default 1: bits moved per shift or rotate operation; 1 ≤ STEP < N.
- DEPTH (localparam) = ceil(N/STEP): the number of shift steps needed to drain a loaded word.
- CW (localparam) = $clog2(DEPTH+1): the counter width.
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; when low, all state holds regardless of op.
- op  input  3  operation select (encoding under Operation).
- d  input  N  parallel load data.
- sin_l  input  STEP  serial data entering the LSB end on left shifts.
- sin_r  input  STEP  serial data entering the MSB end on right shifts.
- q  output  N  register contents.
- sout_l  output  STEP  q[N-1 -: STEP], the bits leaving on the next left shift.
- sout_r  output  STEP  q[STEP-1:0], the bits leaving on the next right shift.
- cnt  output  CW  shift steps since the last LOAD or CLR; saturates at DEPTH.
- drained  output  1  high exactly when cnt == DEPTH.

## Operation
- Reset (rst low): asynchronously sets q = 0, cnt = 0 and drained = 0, at any time including mid-sequence. Operation resumes on the first rising edge after rst goes high.
- When en = 0, q and cnt hold.
- When en = 1, op selects the operation:
  - 000 HOLD: no change.
  - 001 SHL: q <= {q[N-STEP-1:0], sin_l}.
  - 010 SHR: q <= {sin_r, q[N-1:STEP]}.
  - 011 ASR: q <= {{STEP{q[N-1]}}, q[N-1:STEP]}; sin_r is ignored.
  - 100 LOAD: q <= d; cnt <= 0.
  - 101 ROL: q <= {q[N-STEP-1:0], q[N-1 -: STEP]}.
  - 110 ROR: q <= {q[STEP-1:0], q[N-1:STEP]}.
  - 111 CLR: q <= 0; cnt <= 0.
- Counter:
  - Every executed SHL, SHR, ASR, ROL or ROR increments cnt by 1, saturating at DEPTH.
  - Saturation does not block the shift itself; q keeps shifting.
  - HOLD leaves cnt unchanged.
- drained is registered alongside cnt. It is never a combinational compare on the output path.
- The inputs have no illegal combinations; every op value is defined.

## Timing
- Single-cycle latency: an operation sampled on edge k is visible on q, cnt and drained after edge k.
- sout_l and sout_r are direct slices of the q flops and carry no added logic depth.
- en, op, d, sin_l and sin_r are sampled only at the rising edge of clk.
- Back-to-back operations on consecutive cycles are legal with no bubbles.
- Reset takes effect asynchronously. Reset release is assumed synchronous to clk upstream.

## Configuration
- USR_ROTATE_EN defined: ROL and ROR behave as specified above.
- USR_ROTATE_EN undefined:
  - op 101 and 110 behave exactly as HOLD, leaving q and cnt unchanged.
  - No rotate multiplexer legs are synthesised.
- All other operations are identical in both builds.

## Structure
- Package usr_pkg holds:
  - typedef enum logic [2:0] usr_op_e {USR_HOLD, USR_SHL, USR_SHR, USR_ASR, USR_LOAD, USR_ROL, USR_ROR, USR_CLR}, encoded 000 through 111.
  - A function computing DEPTH from N and STEP.
- Sub-module usr_next_value: purely combinational, parameters N and STEP. It maps (q, op, d, sin_l, sin_r) to the next q and an is_shift flag.
- The top level instantiates usr_next_value and owns the q, cnt and drained flops and the saturation logic.

## Test plan
- Reset during shifting: N=8. Assert rst mid-sequence → q=0x00, cnt=0 and drained=0 before the next clock edge; holding en=1 with op=SHL during reset causes no change.
- Shift left: LOAD 0xA5, then three SHL with sin_l=1 → q = 0x4B, 0x97, 0x2F. sout_l before each shift = 1, 0, 1. cnt = 1, 2, 3.
- Right shifts: from 0x80, ASR twice → 0xC0 then 0xE0. From 0x80, SHR with sin_r=0 → 0x40.
- Drain and saturation: LOAD 0xFF, then nine SHR with sin_r=0 → after the 8th shift q=0x00, cnt=8, drained=1. After the 9th, cnt stays 8 and drained stays 1. A following LOAD gives cnt=0 and drained=0.
- Rotate build check: LOAD 0x81, then ROL.
  - With USR_ROTATE_EN → q=0x03, cnt=1.
  - Without USR_ROTATE_EN → q=0x81, cnt=0.
- Enable and STEP: with en=0 and op=CLR, q=0x5A is unchanged. With N=8, STEP=4: LOAD 0x12, then SHL with sin_l=0xF → q=0x2F, cnt=1, and DEPTH=2.
